// File: rtl/button_event_gen.sv
// button_event_gen: turns a debounced button level into press/release/long/repeat strobes and a held level
module button_event_gen #(
  parameter int CLK_FREQ  = 25_000_000,
  parameter int LONG_MS   = 500,
  parameter int REPEAT_MS = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);
  localparam int LONG_CYCLES   = (CLK_FREQ / 1000) * LONG_MS;
  localparam int REPEAT_CYCLES = (CLK_FREQ / 1000) * REPEAT_MS;
  localparam int MAX_CYCLES    = LONG_CYCLES > REPEAT_CYCLES ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int W             = $clog2(MAX_CYCLES + 1);
  localparam logic [W-1:0] LONG_LAST   = W'(LONG_CYCLES - 1);
  localparam logic [W-1:0] REPEAT_LAST = W'(REPEAT_CYCLES - 1);
  typedef enum logic [1:0] {ARM, IDLE, PRESS, REPEAT} state_t;
  state_t state, state_n;
  logic [W-1:0] cnt, cnt_n;
  logic press_n, release_n, long_n, repeat_n, held_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state         <= ARM;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      press_pulse   <= press_n;
      release_pulse <= release_n;
      long_pulse    <= long_n;
      repeat_pulse  <= repeat_n;
      held          <= held_n;
    end
  // release is tested before timer expiry so a release edge never also fires long/repeat
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    press_n   = 1'b0;
    release_n = 1'b0;
    long_n    = 1'b0;
    repeat_n  = 1'b0;
    case (state)
      ARM:
        state_n = btn_level ? ARM : IDLE;
      IDLE:
        if (btn_level) begin
          state_n = PRESS;
          press_n = 1'b1;
          cnt_n   = '0;
        end
      PRESS:
        if (!btn_level) begin
          state_n   = IDLE;
          release_n = 1'b1;
          cnt_n     = '0;
        end else if (cnt == LONG_LAST) begin
          state_n = REPEAT;
          long_n  = 1'b1;
          cnt_n   = '0;
        end else
          cnt_n = cnt + W'(1);
      REPEAT:
        if (!btn_level) begin
          state_n   = IDLE;
          release_n = 1'b1;
          cnt_n     = '0;
        end else if (cnt == REPEAT_LAST) begin
          repeat_n = 1'b1;
          cnt_n    = '0;
        end else
          cnt_n = cnt + W'(1);
    endcase
    held_n = (state_n == PRESS) || (state_n == REPEAT);
  end
endmodule

// File: tb/tb_button_event_gen.sv
// tb_button_event_gen: scenario tasks with a per-cycle expected-output scoreboard
module tb_button_event_gen;
  logic clk = 1'b0, rst = 1'b1, btn_level = 1'b0;
  logic press_pulse, release_pulse, long_pulse, repeat_pulse, held;
  int checks = 0, errors = 0;
  logic [4:0] sb[$];
  logic [4:0] got, exp;
  button_event_gen #(.CLK_FREQ(1000), .LONG_MS(5), .REPEAT_MS(2)) dut (
    .clk(clk), .rst(rst), .btn_level(btn_level),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .long_pulse(long_pulse), .repeat_pulse(repeat_pulse), .held(held)
  );
  always #5 clk = ~clk;
  // output vector order: {press, release, long, repeat, held}
  assign got = {press_pulse, release_pulse, long_pulse, repeat_pulse, held};
  task automatic tick(input logic b);
    @(negedge clk) btn_level = b;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1; btn_level = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (got !== 5'b0) begin errors++; $display("FAIL reset_state got=%b exp=%b", got, 5'b0); end
    @(negedge clk) rst = 1'b0;
    sb.push_back(5'b0); tick(1'b0); exp = sb.pop_front(); checks++;
    if (got !== exp) begin errors++; $display("FAIL arm_to_idle got=%b exp=%b", got, exp); end
  endtask
  task automatic test_short_press();
    for (int i = 0; i < 5; i++) begin
      sb.push_back(i == 0 ? 5'b10001 : i < 3 ? 5'b00001 : i == 3 ? 5'b01000 : 5'b00000);
      tick(i < 3);
      exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL short_press E%0d got=%b exp=%b", i, got, exp); end
    end
  endtask
  task automatic test_long_repeat();
    for (int i = 0; i < 14; i++) begin
      sb.push_back(i == 0 ? 5'b10001 : i == 5 ? 5'b00101 : (i == 7 || i == 9 || i == 11) ? 5'b00011 :
                   i < 12 ? 5'b00001 : i == 12 ? 5'b01000 : 5'b00000);
      tick(i < 12);
      exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL long_repeat E%0d got=%b exp=%b", i, got, exp); end
    end
  endtask
  task automatic test_release_wins();
    for (int i = 0; i < 8; i++) begin
      sb.push_back(i == 0 ? 5'b10001 : i < 5 ? 5'b00001 : i == 5 ? 5'b01000 : 5'b00000);
      tick(i < 5);
      exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL release_wins E%0d got=%b exp=%b", i, got, exp); end
    end
  endtask
  task automatic test_held_through_reset();
    @(negedge clk) begin rst = 1'b1; btn_level = 1'b1; end
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 13; i++) begin
      sb.push_back(i == 11 ? 5'b10001 : i == 12 ? 5'b01000 : 5'b00000);
      tick(!(i == 10 || i == 12));
      exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL held_through_reset C%0d got=%b exp=%b", i, got, exp); end
    end
  endtask
  task automatic test_reset_mid_press();
    for (int i = 0; i < 3; i++) begin
      sb.push_back(i == 0 ? 5'b10001 : 5'b00001);
      tick(1'b1);
      exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL mid_press_pre E%0d got=%b exp=%b", i, got, exp); end
    end
    @(negedge clk) rst = 1'b1;
    #1;
    checks++;
    if (got !== 5'b0) begin errors++; $display("FAIL mid_press_async got=%b exp=%b", got, 5'b0); end
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sb.push_back(5'b00000);
      tick(i < 7);
      exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL mid_press_post C%0d got=%b exp=%b", i, got, exp); end
    end
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      sb.push_back((i == 0 || i == 3) ? 5'b10001 : (i == 2 || i == 10) ? 5'b01000 :
                   i == 8 ? 5'b00101 : i == 11 ? 5'b00000 : 5'b00001);
      tick(!(i == 2 || i >= 10));
      exp = sb.pop_front(); checks++;
      if (got !== exp) begin errors++; $display("FAIL back_to_back E%0d got=%b exp=%b", i, got, exp); end
    end
  endtask
  initial begin
    test_reset();
    test_short_press();
    test_long_repeat();
    test_release_wins();
    test_held_through_reset();
    test_reset_mid_press();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
